// File: rtl/caixa_pagamento.sv
// rtl/caixa_pagamento.sv - coffee vending payment controller
// Credits coins, judges selections, drives the dispenser and releases change.
module caixa_pagamento #(
  parameter int PRECO_0     = 100,
  parameter int PRECO_1     = 150,
  parameter int PRECO_2     = 200,
  parameter int CREDITO_MAX = 300,
  parameter int TIMEOUT     = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] MOEDA,
  input  logic [1:0] SEL,
  input  logic       SEL_VALID,
  input  logic       CANCEL,
  input  logic       F,
  output logic [1:0] TIPO,
  output logic       INICIA,
  output logic [8:0] CREDITO,
  output logic [8:0] TROCO,
  output logic       TROCO_VALID,
  output logic       MOEDA_REJ,
  output logic       FALTA,
  output logic       OCUPADO,
  output logic       ERRO
);

  localparam logic [8:0] P0   = 9'(PRECO_0);
  localparam logic [8:0] P1   = 9'(PRECO_1);
  localparam logic [8:0] P2   = 9'(PRECO_2);
  localparam logic [9:0] CMAX = 10'(CREDITO_MAX);
  localparam int         CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DISPENSA = 2'd1,
    AGUARDA  = 2'd2,
    DEVOLVE  = 2'd3
  } estado_t;

  estado_t       state_q, state_d;
  logic [8:0]    credito_q, credito_d;
  logic [8:0]    preco_q, preco_d;
  logic [1:0]    tipo_q, tipo_d;
  logic [8:0]    troco_q, troco_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          erro_q, erro_d;
  logic          inicia_q, inicia_d;
  logic          troco_valid_q, troco_valid_d;
  logic          moeda_rej_q, moeda_rej_d;
  logic          falta_q, falta_d;
  logic          ocupado_q, ocupado_d;

  logic [8:0] valor;
  logic [9:0] soma;
  logic [8:0] preco_sel;

  always_comb begin
    case (MOEDA)
      2'b01:   valor = 9'd25;
      2'b10:   valor = 9'd50;
      2'b11:   valor = 9'd100;
      default: valor = 9'd0;
    endcase
    case (SEL)
      2'd0:    preco_sel = P0;
      2'd1:    preco_sel = P1;
      2'd2:    preco_sel = P2;
      default: preco_sel = 9'd0;
    endcase
    soma = {1'b0, credito_q} + {1'b0, valor};
  end

  always_comb begin
    state_d       = state_q;
    credito_d     = credito_q;
    preco_d       = preco_q;
    tipo_d        = tipo_q;
    troco_d       = troco_q;
    cnt_d         = cnt_q;
    erro_d        = erro_q;
    inicia_d      = 1'b0;
    troco_valid_d = 1'b0;
    moeda_rej_d   = 1'b0;
    falta_d       = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (MOEDA != 2'b00) begin
          if (soma <= CMAX) credito_d = soma[8:0];
          else              moeda_rej_d = 1'b1;
        end
        // Decisions use the pre-coin credit; a same-cycle coin still lands in the refund.
        if (CANCEL && credito_q != 9'd0) begin
          state_d       = DEVOLVE;
          troco_d       = credito_d;
          troco_valid_d = 1'b1;
        end else if (SEL_VALID) begin
          if (SEL != 2'd3 && credito_q >= preco_sel) begin
            state_d  = DISPENSA;
            tipo_d   = SEL;
            preco_d  = preco_sel;
            inicia_d = 1'b1;
          end else begin
            falta_d = 1'b1;
          end
        end
      end
      DISPENSA: begin
        state_d = AGUARDA;
        cnt_d   = '0;
      end
      AGUARDA: begin
        if (F) begin
          state_d       = DEVOLVE;
          troco_d       = credito_q - preco_q;
          troco_valid_d = 1'b1;
        end else if (cnt_q == CNT_FIM) begin
          state_d       = DEVOLVE;
          erro_d        = 1'b1;
          troco_d       = credito_q;
          troco_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEVOLVE: begin
        state_d   = OCIOSO;
        credito_d = 9'd0;
      end
      default: state_d = OCIOSO;
    endcase

    if (state_q != OCIOSO && MOEDA != 2'b00) moeda_rej_d = 1'b1;
    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= OCIOSO;
      credito_q     <= 9'd0;
      preco_q       <= 9'd0;
      tipo_q        <= 2'd0;
      troco_q       <= 9'd0;
      cnt_q         <= '0;
      erro_q        <= 1'b0;
      inicia_q      <= 1'b0;
      troco_valid_q <= 1'b0;
      moeda_rej_q   <= 1'b0;
      falta_q       <= 1'b0;
      ocupado_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credito_q     <= credito_d;
      preco_q       <= preco_d;
      tipo_q        <= tipo_d;
      troco_q       <= troco_d;
      cnt_q         <= cnt_d;
      erro_q        <= erro_d;
      inicia_q      <= inicia_d;
      troco_valid_q <= troco_valid_d;
      moeda_rej_q   <= moeda_rej_d;
      falta_q       <= falta_d;
      ocupado_q     <= ocupado_d;
    end
  end

  assign TIPO        = tipo_q;
  assign INICIA      = inicia_q;
  assign CREDITO     = credito_q;
  assign TROCO       = troco_q;
  assign TROCO_VALID = troco_valid_q;
  assign MOEDA_REJ   = moeda_rej_q;
  assign FALTA       = falta_q;
  assign OCUPADO     = ocupado_q;
  assign ERRO        = erro_q;

endmodule
